wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//  Writeback-side producer for the 32x32 register file's single write port
//  (the register file commits on negedge clk). Accepts results from the ALU
//  and load/memory paths through valid/ready handshakes and buffers them in
//  an in-order queue. Drains one write per cycle onto rf_we/rf_wr_addr/rf_wr_data.
//  Provides youngest-match forwarding of still-uncommitted results to decode.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >=2
//  DATA_W  32  result width
//  ADDR_W  5   register index width
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       asynchronous reset, active-high
//  alu_valid    in   1       ALU result offered
//  alu_rd       in   ADDR_W  ALU destination register
//  alu_data     in   DATA_W  ALU result
//  alu_ready    out  1       ALU transfer accepted this cycle
//  mem_valid    in   1       load result offered
//  mem_rd       in   ADDR_W  load destination register
//  mem_data     in   DATA_W  load result
//  mem_ready    out  1       load transfer accepted this cycle
//  rf_we        out  1       register-file write enable (registered)
//  rf_wr_addr   out  ADDR_W  register-file write address (registered)
//  rf_wr_data   out  DATA_W  register-file write data (registered)
//  fwd_rs       in   ADDR_W  forwarding lookup A
//  fwd_rs_hit   out  1       pending result exists for fwd_rs
//  fwd_rs_data  out  DATA_W  youngest pending value for fwd_rs
//  fwd_rt       in   ADDR_W  forwarding lookup B
//  fwd_rt_hit   out  1       pending result exists for fwd_rt
//  fwd_rt_data  out  DATA_W  youngest pending value for fwd_rt
//  count        out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (rst=1, async): count=0, rd/wr pointers=0, rf_we=0, rf_wr_addr=0,
//    rf_wr_data=0; queued entries discarded. Reset mid-drain drops all pending.
//  - free = DEPTH - count (current count; a same-cycle pop gives no credit).
//  - alu_ready = (alu_rd==0) | (free>=1).
//  - mem_ready = (mem_rd==0) | (free >= 1 + (alu_valid & alu_rd!=0)).
//  - Transfer = valid & ready. rd==0 transfers complete but store nothing.
//  - Same-cycle ALU and mem transfers: ALU entry is older (enqueued first).
//  - Drain: at posedge, if count>0, pop head -> rf_we<=1, rf_wr_addr<=rd,
//    rf_wr_data<=data; else rf_we<=0 (addr/data hold).
//  - count_next = count + enqueued(0..2) - popped(0..1); never exceeds DEPTH.
//  - Latency: entry enqueued at edge N pops at earliest edge N+1. rf_we is
//    high in cycle N+1. Register file commits at the negedge inside that cycle.
//  - Pointers wrap modulo DEPTH; FIFO order strictly preserved.
//  - Forwarding (combinational): search the queued entries and the
//    registered rf_wr_* (when rf_we=1). Youngest match wins (queue tail
//    first, rf_wr_* oldest). Address 0 never hits; miss -> hit=0, data=0.
//    Same-cycle incoming transfers are not visible.
// STRUCTURE
//  - Shared package wb_pkg: DATA_W/ADDR_W constants, wb_entry_t {rd, data}.
//  - Sub-module wb_fifo: circular buffer, 2 write ports (ordered),
//    1 read port, exposes all entries plus age order for forwarding search.
//  - Top: ready logic, rd==0 filter, output registers, forwarding priority mux.
// TESTING
//  1. Reset, alu r5=0x11 at edge0 -> cycle1 rf_we=1, addr=5, data=0x11.
//     cycle2 rf_we=0, count=0.
//  2. alu r3=0xA and mem r4=0xB in the same cycle -> two consecutive writes:
//     r3 then r4; count peaks at 2.
//  3. Fill DEPTH=4 with no ... n/a; offer alu+mem with count=3 ->
//     alu_ready=1, mem_ready=0. Mem stalls one cycle, then is accepted.
//  4. alu rd=0 data=0xFF -> alu_ready=1 even when full; no entry; rf_we never
//     targets 0; fwd lookup of 0 -> hit=0.
//  5. Queue r7=1 then r7=2, fwd_rs=7 -> hit=1, data=2. After both drain and
//     rf_we drops -> hit=0.
//  6. Assert rst with count=3, rf_we=1 -> outputs 0 immediately (async),
//     count=0, no further writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback types: register-file geometry and the queued result payload.
package wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer with two ordered write ports and one read port;
// exposes every slot in age order (index 0 = head/oldest) for forwarding.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0,
  input  wb_entry_t                 push0_entry,
  input  logic                      push1,
  input  wb_entry_t                 push1_entry,
  input  logic                      pop,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output wb_entry_t [DEPTH-1:0]     age_entry,
  output logic [DEPTH-1:0]          age_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr1;

  // push1 lands behind push0 when both fire, so port 0 is always older
  always_comb begin
    mem_d    = mem_q;
    wr1      = push0 ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    if (push0) mem_d[wr_ptr_q] = push0_entry;
    if (push1) mem_d[wr1]      = push1_entry;
    wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(push0) + PTR_W'(push1));
    rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(pop));
    count_d  = CNT_W'(count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_entry[i] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
      age_valid[i] = (CNT_W'(i) < count_q);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue: merges ALU and load results in order, drains one register
// write per cycle and forwards the youngest uncommitted value to decode.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0]      rf_wr_data,
  input  logic [ADDR_W-1:0]      fwd_rs,
  output logic                   fwd_rs_hit,
  output logic [DATA_W-1:0]      fwd_rs_data,
  input  logic [ADDR_W-1:0]      fwd_rt,
  output logic                   fwd_rt_hit,
  output logic [DATA_W-1:0]      fwd_rt_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  push0, push1, pop;
  logic                  alu_live;
  logic [CNT_W-1:0]      free, mem_need;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] age_entry;
  logic [DEPTH-1:0]      age_valid;

  logic                  rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]     rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0]     rf_wr_data_q, rf_wr_data_d;

  // Credit uses the current occupancy only; a same-cycle pop frees nothing
  always_comb begin
    alu_live  = alu_valid && (alu_rd != '0);
    free      = CNT_W'(CNT_W'(DEPTH) - count);
    mem_need  = CNT_W'(CNT_W'(1) + CNT_W'(alu_live));
    alu_ready = (alu_rd == '0) || (free >= CNT_W'(1));
    mem_ready = (mem_rd == '0) || (free >= mem_need);
    push0     = alu_live && alu_ready;
    push1     = mem_valid && mem_ready && (mem_rd != '0);
    pop       = (count != '0);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (push0),
    .push0_entry ('{rd: alu_rd, data: alu_data}),
    .push1       (push1),
    .push1_entry ('{rd: mem_rd, data: mem_data}),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .age_entry   (age_entry),
    .age_valid   (age_valid)
  );

  always_comb begin
    rf_we_d      = pop;
    rf_wr_addr_d = pop ? head.rd   : rf_wr_addr_q;
    rf_wr_data_d = pop ? head.data : rf_wr_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;

  // Oldest source first so later (younger) matches override
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = '0;
    if (rf_we_q && (fwd_rs != '0) && (rf_wr_addr_q == fwd_rs)) begin
      fwd_rs_hit  = 1'b1;
      fwd_rs_data = rf_wr_data_q;
    end
    if (rf_we_q && (fwd_rt != '0) && (rf_wr_addr_q == fwd_rt)) begin
      fwd_rt_hit  = 1'b1;
      fwd_rt_data = rf_wr_data_q;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (age_valid[i] && (fwd_rs != '0) && (age_entry[i].rd == fwd_rs)) begin
        fwd_rs_hit  = 1'b1;
        fwd_rs_data = age_entry[i].data;
      end
      if (age_valid[i] && (fwd_rt != '0) && (age_entry[i].rd == fwd_rt)) begin
        fwd_rt_hit  = 1'b1;
        fwd_rt_data = age_entry[i].data;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: ordering, backpressure, rd==0 filtering,
// forwarding priority and asynchronous reset.
module tb_wb_write_queue;

  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, fwd_rs, fwd_rt;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .fwd_rs(fwd_rs), .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt(fwd_rt), .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic offer(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); fwd_rs = 5'd5; fwd_rt = 5'd0;
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0h exp 0", rf_we); end
    checks++; if (rf_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", rf_wr_addr); end
    checks++; if (rf_wr_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", rf_wr_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (fwd_rs_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd got %0h exp 0", fwd_rs_hit); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    offer(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0h exp 1", alu_ready); end
    tick(); idle(); fwd_rs = 5'd5; #1;
    checks++; if (count !== 3'd1 || rf_we !== 1'b0) begin errors++; $display("FAIL single_enq got count=%0d we=%0h exp count=1 we=0", count, rf_we); end
    checks++; if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'h11) begin errors++; $display("FAIL single_fwdq got %0h/%0h exp 1/11", fwd_rs_hit, fwd_rs_data); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h11) begin errors++; $display("FAIL single_wr got we=%0h a=%0d d=%0h exp 1/5/11", rf_we, rf_wr_addr, rf_wr_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_cnt got %0d exp 0", count); end
    checks++; if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'h11) begin errors++; $display("FAIL single_fwdrf got %0h/%0h exp 1/11", fwd_rs_hit, fwd_rs_data); end
    tick();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0 || rf_wr_addr !== 5'd5) begin errors++; $display("FAIL single_done got we=%0h c=%0d a=%0d exp 0/0/5", rf_we, count, rf_wr_addr); end
    checks++; if (fwd_rs_hit !== 1'b0 || fwd_rs_data !== 32'h0) begin errors++; $display("FAIL single_fwdmiss got %0h/%0h exp 0/0", fwd_rs_hit, fwd_rs_data); end
  endtask

  task automatic test_dual();
    offer(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL dual_ready got %0h/%0h exp 1/1", alu_ready, mem_ready); end
    tick(); idle();
    checks++; if (count !== 3'd2 || rf_we !== 1'b0) begin errors++; $display("FAIL dual_peak got c=%0d we=%0h exp 2/0", count, rf_we); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'hA || count !== 3'd1) begin errors++; $display("FAIL dual_first got we=%0h a=%0d d=%0h c=%0d exp 1/3/a/1", rf_we, rf_wr_addr, rf_wr_data, count); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wr_addr !== 5'd4 || rf_wr_data !== 32'hB || count !== 3'd0) begin errors++; $display("FAIL dual_second got we=%0h a=%0d d=%0h c=%0d exp 1/4/b/0", rf_we, rf_wr_addr, rf_wr_data, count); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL dual_idle got %0h exp 0", rf_we); end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_a [4];
    exp_a[0] = 5'd10; exp_a[1] = 5'd11; exp_a[2] = 5'd1; exp_a[3] = 5'd2;
    offer(1'b1, 5'd8, 32'h80, 1'b1, 5'd9, 32'h90);
    tick();
    offer(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_free2 got %0h exp 1", mem_ready); end
    tick();
    checks++; if (count !== 3'd3 || rf_wr_addr !== 5'd8) begin errors++; $display("FAIL bp_fill got c=%0d a=%0d exp 3/8", count, rf_wr_addr); end
    offer(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %0h/%0h exp 1/0", alu_ready, mem_ready); end
    tick();
    checks++; if (count !== 3'd3 || rf_wr_addr !== 5'd9) begin errors++; $display("FAIL bp_alu got c=%0d a=%0d exp 3/9", count, rf_wr_addr); end
    offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h2);
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %0h exp 1", mem_ready); end
    tick(); idle();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL bp_cnt got %0d exp 3", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rf_we !== 1'b1 || rf_wr_addr !== exp_a[i]) begin errors++; $display("FAIL bp_order%0d got we=%0h a=%0d exp 1/%0d", i, rf_we, rf_wr_addr, exp_a[i]); end
      tick();
    end
    checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL bp_drain got we=%0h c=%0d exp 0/0", rf_we, count); end
  endtask

  task automatic test_rd_zero();
    logic [4:0] exp_a [3];
    exp_a[0] = 5'd15; exp_a[1] = 5'd16; exp_a[2] = 5'd17;
    offer(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
    tick();
    offer(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF);
    tick();
    offer(1'b1, 5'd0, 32'hFF, 1'b1, 5'd16, 32'h16);
    fwd_rs = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rz_alu0 got %0h/%0h exp 1/1", alu_ready, mem_ready); end
    checks++; if (fwd_rs_hit !== 1'b0 || fwd_rs_data !== 32'h0) begin errors++; $display("FAIL rz_fwd0 got %0h/%0h exp 0/0", fwd_rs_hit, fwd_rs_data); end
    tick();
    checks++; if (count !== 3'd3 || rf_wr_addr !== 5'd13) begin errors++; $display("FAIL rz_skip got c=%0d a=%0d exp 3/13", count, rf_wr_addr); end
    offer(1'b1, 5'd17, 32'h17, 1'b1, 5'd0, 32'hEE);
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rz_mem0 got %0h/%0h exp 1/1", alu_ready, mem_ready); end
    tick(); idle();
    checks++; if (count !== 3'd3 || rf_wr_addr !== 5'd14) begin errors++; $display("FAIL rz_skip2 got c=%0d a=%0d exp 3/14", count, rf_wr_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wr_addr !== exp_a[i]) begin errors++; $display("FAIL rz_order%0d got we=%0h a=%0d exp 1/%0d", i, rf_we, rf_wr_addr, exp_a[i]); end
      if (i == 1) begin
        checks++; if (rf_wr_data !== 32'h16) begin errors++; $display("FAIL rz_data got %0h exp 16", rf_wr_data); end
      end
    end
    tick();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rz_drain got we=%0h c=%0d exp 0/0", rf_we, count); end
  endtask

  task automatic test_forward();
    offer(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0);
    tick();
    offer(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0);
    fwd_rs = 5'd7; fwd_rt = 5'd9;
    #1;
    checks++; if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'h1) begin errors++; $display("FAIL fw_incoming got %0h/%0h exp 1/1", fwd_rs_hit, fwd_rs_data); end
    checks++; if (fwd_rt_hit !== 1'b0 || fwd_rt_data !== 32'h0) begin errors++; $display("FAIL fw_miss got %0h/%0h exp 0/0", fwd_rt_hit, fwd_rt_data); end
    tick(); idle();
    checks++; if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'h2) begin errors++; $display("FAIL fw_young got %0h/%0h exp 1/2", fwd_rs_hit, fwd_rs_data); end
    tick();
    checks++; if (fwd_rs_hit !== 1'b1 || fwd_rs_data !== 32'h2 || rf_wr_data !== 32'h2) begin errors++; $display("FAIL fw_rf got %0h/%0h exp 1/2", fwd_rs_hit, fwd_rs_data); end
    tick();
    checks++; if (fwd_rs_hit !== 1'b0 || fwd_rs_data !== 32'h0) begin errors++; $display("FAIL fw_gone got %0h/%0h exp 0/0", fwd_rs_hit, fwd_rs_data); end
    offer(1'b1, 5'd6, 32'h5, 1'b1, 5'd6, 32'h6);
    fwd_rt = 5'd6;
    tick(); idle();
    checks++; if (fwd_rt_hit !== 1'b1 || fwd_rt_data !== 32'h6) begin errors++; $display("FAIL fw_memyoung got %0h/%0h exp 1/6", fwd_rt_hit, fwd_rt_data); end
    tick();
    checks++; if (fwd_rt_data !== 32'h6 || rf_wr_data !== 32'h5) begin errors++; $display("FAIL fw_qoverrf got %0h rf=%0h exp 6/5", fwd_rt_data, rf_wr_data); end
    tick(); tick();
    fwd_rs = 5'd0; fwd_rt = 5'd0;
  endtask

  task automatic test_async_reset();
    offer(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
    tick();
    offer(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
    tick(); idle();
    checks++; if (count !== 3'd3 || rf_we !== 1'b1) begin errors++; $display("FAIL ar_pre got c=%0d we=%0h exp 3/1", count, rf_we); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0 || count !== 3'd0) begin errors++; $display("FAIL ar_async got we=%0h a=%0d d=%0h c=%0d exp all 0", rf_we, rf_wr_addr, rf_wr_data, count); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL ar_after%0d got we=%0h c=%0d exp 0/0", i, rf_we, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_backpressure();
    test_rd_zero();
    test_forward();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
